// File: rtl/cosim_commit_queue.sv
// Commit-stage capture and in-order FIFO feeding the per-hart Spike co-simulation scoreboard.
// Commits are discarded until START_PC is seen, then buffered and presented over valid/ready.
module cosim_commit_queue #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PC_VA_BITS = 40,
    parameter logic [63:0] START_PC   = 64'h0000_0000_8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_commit,
    input  logic                     in_stall_exe,
    input  logic [63:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic [4:0]               in_xreg_dest,
    input  logic                     in_wr_en,
    input  logic [63:0]              in_data,
    input  logic                     in_excep,
    input  logic [63:0]              in_cause,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [4:0]               out_xreg_dest,
    output logic                     out_xreg_wr_valid,
    output logic [63:0]              out_data,
    output logic                     out_excep,
    output logic [63:0]              out_cause,
    output logic                     armed,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [4:0]  dest;
        logic        wr_valid;
        logic [63:0] data;
        logic        excep;
        logic [63:0] cause;
    } entry_t;

    typedef enum logic {IDLE, ARMED} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];

    entry_t          in_entry;
    entry_t          head;
    logic [63:0]     pc_ext;
    logic            cap, start_hit, push, pop, full, accept;

    always_comb begin
        pc_ext    = {{(64-PC_VA_BITS){in_pc[PC_VA_BITS-1]}}, in_pc[PC_VA_BITS-1:0]};
        cap       = in_commit && !in_stall_exe;
        start_hit = (pc_ext == START_PC);
        push      = cap && ((state_q == ARMED) || start_hit);
        out_valid = (count_q != '0);
        pop       = out_valid && out_ready;
        full      = (count_q == FULL_CNT);
        // A full queue still takes the new entry when the head leaves on the same edge.
        accept    = push && (!full || pop);

        in_entry          = '0;
        in_entry.pc       = pc_ext;
        in_entry.instr    = in_instr;
        in_entry.dest     = in_xreg_dest;
        in_entry.wr_valid = in_wr_en && (in_xreg_dest != 5'd0);
        in_entry.data     = in_data;
        in_entry.excep    = in_excep;
        in_entry.cause    = in_cause;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && cap && start_hit) begin
            state_d = ARMED;
        end
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + (AW+1)'(accept) - (AW+1)'(pop);
        overflow_d = overflow_q || (push && full && !pop);
        if (accept) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Data fields are forced to zero whenever the queue is empty so reset reads clean.
    always_comb begin
        head              = out_valid ? mem_q[rd_ptr_q] : '0;
        out_pc            = head.pc;
        out_instr         = head.instr;
        out_xreg_dest     = head.dest;
        out_xreg_wr_valid = head.wr_valid;
        out_data          = head.data;
        out_excep         = head.excep;
        out_cause         = head.cause;
        armed             = (state_q == ARMED);
        overflow          = overflow_q;
        count             = count_q;
    end
endmodule

// File: tb/tb_cosim_commit_queue.sv
// Directed bench for cosim_commit_queue: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_cosim_commit_queue;
    localparam logic [63:0] START = 64'h0000_0000_8000_0000;
    localparam int MDEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_commit = 1'b0, in_stall_exe = 1'b0, in_wr_en = 1'b0, in_excep = 1'b0;
    logic [63:0] in_pc = '0, in_data = '0, in_cause = '0;
    logic [31:0] in_instr = '0;
    logic [4:0]  in_xreg_dest = '0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_xreg_wr_valid, out_excep, armed, overflow;
    logic [63:0] out_pc, out_data, out_cause;
    logic [31:0] out_instr;
    logic [4:0]  out_xreg_dest;
    logic [3:0]  count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [4:0]  dest;
        logic        wv;
        logic [63:0] data;
        logic        ex;
        logic [63:0] cause;
    } ent_t;

    ent_t q[$];
    logic m_armed = 1'b0;
    logic m_ovf   = 1'b0;
    logic m_hold  = 1'b0;

    cosim_commit_queue #(
        .DEPTH(8),
        .PC_VA_BITS(40),
        .START_PC(64'h0000_0000_8000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .in_commit(in_commit), .in_stall_exe(in_stall_exe),
        .in_pc(in_pc), .in_instr(in_instr), .in_xreg_dest(in_xreg_dest),
        .in_wr_en(in_wr_en), .in_data(in_data), .in_excep(in_excep), .in_cause(in_cause),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_xreg_dest(out_xreg_dest),
        .out_xreg_wr_valid(out_xreg_wr_valid), .out_data(out_data),
        .out_excep(out_excep), .out_cause(out_cause),
        .armed(armed), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sext40(input logic [63:0] pc);
        logic [63:0] m;
        m = (64'd1 << 40) - 64'd1;
        if (pc[39]) return pc | ~m;
        return pc & m;
    endfunction

    // Reference model: plain queue, updated once per rising edge or on reset.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_armed = 1'b0;
                m_ovf   = 1'b0;
                m_hold  = 1'b0;
            end else begin
                logic cap, pop, push;
                logic [63:0] pcx;
                ent_t e;
                cap  = in_commit && !in_stall_exe;
                pcx  = sext40(in_pc);
                pop  = (q.size() != 0) && out_ready;
                m_hold = (q.size() != 0) && !out_ready;
                push = cap && (m_armed || pcx == START);
                if (cap && pcx == START) m_armed = 1'b1;
                e = '{pc: pcx, instr: in_instr, dest: in_xreg_dest,
                      wv: in_wr_en && (in_xreg_dest != 0), data: in_data,
                      ex: in_excep, cause: in_cause};
                if (pop) void'(q.pop_front());
                if (push) begin
                    if (q.size() < MDEPTH) q.push_back(e);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus output stability under backpressure.
    initial begin
        logic [229:0] snap;
        logic [229:0] cur;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cur = {out_pc, out_instr, out_xreg_dest, out_xreg_wr_valid, out_data, out_excep, out_cause};
                chk("m_count", 64'(count), 64'(q.size()));
                chk("m_armed", 64'(armed), 64'(m_armed));
                chk("m_overflow", 64'(overflow), 64'(m_ovf));
                chk("m_valid", 64'(out_valid), 64'(q.size() != 0));
                if (q.size() != 0) begin
                    chk("m_pc", out_pc, q[0].pc);
                    chk("m_instr", 64'(out_instr), 64'(q[0].instr));
                    chk("m_dest", 64'(out_xreg_dest), 64'(q[0].dest));
                    chk("m_wv", 64'(out_xreg_wr_valid), 64'(q[0].wv));
                    chk("m_data", out_data, q[0].data);
                    chk("m_excep", 64'(out_excep), 64'(q[0].ex));
                    chk("m_cause", out_cause, q[0].cause);
                end
                if (m_hold) chk("hold_stable", 64'(cur == snap), 64'd1);
                snap = cur;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic commit(input logic [63:0] pc, input logic [4:0] dest, input logic [63:0] data,
                          input logic wen);
        in_commit    = 1'b1;
        in_pc        = pc;
        in_instr     = pc[31:0] ^ 32'h0000_0013;
        in_xreg_dest = dest;
        in_wr_en     = wen;
        in_data      = data;
        in_excep     = data[4];
        in_cause     = data ^ 64'h5;
        tick();
        in_commit    = 1'b0;
    endtask

    initial begin
        #22 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_armed", 64'(armed), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_pc", out_pc, 64'd0);

        // Pre-arm filter
        commit(64'h1000, 5'd1, 64'h1, 1'b1);
        commit(64'h1004, 5'd1, 64'h2, 1'b1);
        chk("prearm_count", 64'(count), 64'd0);
        chk("prearm_armed", 64'(armed), 64'd0);
        commit(64'h8000_0000, 5'd1, 64'h3, 1'b1);
        chk("arm_armed", 64'(armed), 64'd1);
        chk("arm_count", 64'(count), 64'd1);
        chk("arm_pc", out_pc, 64'h0000_0000_8000_0000);
        in_stall_exe = 1'b1;
        commit(64'h8000_0004, 5'd1, 64'h4, 1'b1);
        in_stall_exe = 1'b0;
        chk("stall_count", 64'(count), 64'd1);

        // Sign extension
        commit(64'h80_0000_1000, 5'd2, 64'h5, 1'b1);
        chk("sext_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        tick();
        chk("sext_pc", out_pc, 64'hFFFF_FF80_0000_1000);
        tick();
        chk("sext_drained", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Backpressure and order
        commit(64'h8000_0010, 5'd5, 64'h11, 1'b1);
        commit(64'h8000_0014, 5'd6, 64'h22, 1'b1);
        commit(64'h8000_0018, 5'd7, 64'h33, 1'b1);
        tick();
        tick();
        chk("bp_dest0", 64'(out_xreg_dest), 64'd5);
        chk("bp_data0", out_data, 64'h11);
        out_ready = 1'b1;
        tick();
        chk("bp_dest1", 64'(out_xreg_dest), 64'd6);
        chk("bp_data1", out_data, 64'h22);
        tick();
        chk("bp_dest2", 64'(out_xreg_dest), 64'd7);
        chk("bp_data2", out_data, 64'h33);
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Overflow
        for (int i = 1; i <= 9; i++) commit(64'h8000_0100 + 64'(4 * i), 5'd1, 64'(i), 1'b1);
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_drain", out_data, 64'(i));
            tick();
        end
        chk("ovf_drained", 64'(count), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        out_ready = 1'b0;

        // Full with simultaneous push/pop, x0 destination
        for (int i = 1; i <= 8; i++) commit(64'h8000_0200 + 64'(4 * i), 5'd2, 64'h100 + 64'(i), 1'b1);
        chk("full_count", 64'(count), 64'd8);
        out_ready = 1'b1;
        commit(64'h8000_0400, 5'd0, 64'hAA, 1'b1);
        chk("fullpp_count", 64'(count), 64'd8);
        for (int i = 2; i <= 8; i++) begin
            chk("fullpp_drain", out_data, 64'h100 + 64'(i));
            tick();
        end
        chk("x0_data", out_data, 64'hAA);
        chk("x0_wv", 64'(out_xreg_wr_valid), 64'd0);
        tick();
        chk("fullpp_drained", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Mid-operation asynchronous reset
        for (int i = 0; i < 5; i++) commit(64'h8000_0500 + 64'(4 * i), 5'd3, 64'h200 + 64'(i), 1'b1);
        chk("mid_count", 64'(count), 64'd5);
        chk("mid_armed", 64'(armed), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_armed", 64'(armed), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        chk("arst_pc", out_pc, 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        commit(64'h1000, 5'd1, 64'h7, 1'b1);
        chk("post_rst_drop", 64'(count), 64'd0);
        chk("post_rst_armed", 64'(armed), 64'd0);
        commit(START, 5'd1, 64'h8, 1'b1);
        chk("rearm_count", 64'(count), 64'd1);
        chk("rearm_armed", 64'(armed), 64'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cosim_commit_queue.md
Name: cosim_commit_queue

Overview:
Upstream feeder for the per-hart Spike co-simulation scoreboard.
- Samples the core's commit-stage signals: PC, instruction, destination x-reg, write enable, write data, exception and cause.
- Normalises them: sign-extends the PC and qualifies the register write.
- Discards commits before the compare-start PC.
- Buffers the rest in an in-order FIFO and presents them one at a time over a valid/ready handshake, so a stalled checker never loses a commit.

Parameters:
DEPTH, 8, FIFO entries; power of two, >=2
PC_VA_BITS, 40, valid virtual-address bits of in_pc; bit PC_VA_BITS-1 is the sign bit
START_PC, 64'h0000_0000_8000_0000, first sign-extended PC that is enqueued

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
in_commit  in  1  commit strobe from core
in_stall_exe  in  1  execute-stage stall; suppresses capture
in_pc  in  64  commit PC; only [PC_VA_BITS-1:0] meaningful
in_instr  in  32  committed instruction (compressed in [15:0])
in_xreg_dest  in  5  destination x-reg index
in_wr_en  in  1  integer register-file write enable
in_data  in  64  write-back data
in_excep  in  1  exception or CSR exception on this commit
in_cause  in  64  mcause value when in_excep
out_valid  out  1  head entry valid
out_ready  in  1  scoreboard accepts head
out_pc  out  64  sign-extended PC
out_instr  out  32  instruction
out_xreg_dest  out  5  dest index
out_xreg_wr_valid  out  1  in_wr_en && in_xreg_dest!=0
out_data  out  64  write-back data
out_excep  out  1  exception flag
out_cause  out  64  cause
armed  out  1  START_PC has been seen
overflow  out  1  sticky: a commit was dropped
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Capture: cap = in_commit && !in_stall_exe.
- PC extension: pc_ext = {{(64-PC_VA_BITS){in_pc[PC_VA_BITS-1]}}, in_pc[PC_VA_BITS-1:0]}.
- Arm FSM, two states:
  - IDLE: on cap with pc_ext==START_PC, go to ARMED; that commit is enqueued. Other captures in IDLE are discarded and raise no flag.
  - ARMED: every cap is enqueued. Leaves ARMED only on rst.
  - armed = (state==ARMED), registered.
- Push: push = cap && (ARMED || pc_ext==START_PC).
- Pop: pop = out_valid && out_ready.
- FIFO mechanics:
  - First-word-fall-through; out_* are driven from the head slot.
  - out_valid = (count!=0).
  - Read and write pointers wrap modulo DEPTH.
- Latency: a commit captured at edge N is visible on out_* from after edge N until popped. There is no same-cycle bypass: with an empty FIFO, out_valid stays 0 in the capture cycle.
- Hold: while out_valid && !out_ready, every out_* is stable.
- Full: push while count==DEPTH:
  - with pop in the same cycle: accepted, count unchanged;
  - without pop: entry dropped, overflow set to 1 and held until rst, count stays DEPTH.
- Empty: pop cannot occur (out_valid=0); out_ready is ignored.
- Simultaneous push and pop at count 1..DEPTH-1: count unchanged, order preserved.
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid=0, count=0, armed=0, overflow=0, pointers=0;
  - out_* data fields read 0;
  - storage contents are don't-care.
- out_xreg_wr_valid is computed at push time and stored per entry.
- out_excep entries carry whatever in_data, in_wr_en and in_xreg_dest were present; the consumer ignores them.

Test Plan:
- Pre-arm filter:
  - Stimulus: caps at in_pc=0x1000, 0x1004, then 0x80000000.
  - Required: first two dropped; armed=1 after third; out_pc=0x0000000080000000; count=1.
- Sign extension:
  - Stimulus: armed; cap with in_pc=0x80_0000_1000 (PC_VA_BITS=40).
  - Required: out_pc=0xFFFFFF8000001000.
- Backpressure and order:
  - Stimulus: out_ready=0; push 3 commits with x5=0x11, x6=0x22, x7=0x33; then out_ready=1.
  - Required: outputs stable while stalled; pops occur in order 5/0x11, 6/0x22, 7/0x33 on consecutive cycles.
- Overflow:
  - Stimulus: out_ready=0; push 9 commits with DEPTH=8.
  - Required: count=8, overflow=1, 9th lost; draining yields exactly the first 8; overflow stays 1.
- Full with simultaneous push/pop, plus x0 write:
  - Stimulus: count=8, out_ready=1, cap with dest=0, wr_en=1.
  - Required: accepted, count=8; that entry later shows out_xreg_wr_valid=0.
- Mid-operation reset:
  - Stimulus: count=5, armed=1; pulse rst asynchronously between edges.
  - Required: out_valid, count, armed and overflow all go 0 immediately; a following cap at 0x1000 is dropped.
